// File: rtl/yolo_design_wrapper.sv
// ---------------------------------------------------------------------------
// yolo_design_wrapper
//   Streaming per-cell intensity scorer. Pixels arrive in raster order on an
//   AXI-Stream style input. Each pixel's R+G+B is added into the accumulator
//   of its column cell. When the last pixel of a CELL x CELL cell is accepted,
//   one detection result is emitted on the following cycle.
//
// Ports
//   clk                : single clock, rising edge
//   rst_n              : synchronous reset, ACTIVE-HIGH despite the name
//   s_axis_0_0_tdata   : pixel {R[23:16], G[15:8], B[7:0]}
//   s_axis_0_0_tvalid  : pixel valid
//   s_axis_0_0_tready  : high whenever reset is not asserted
//   detect_valid       : one-cycle pulse per completed cell
//   detect_row/col     : cell coordinates
//   detect_score       : mean R+G+B over the cell
//   detect_hit         : detect_score >= THRESH
// ---------------------------------------------------------------------------

// One column-cell accumulator. Cleared when its cell completes so the next
// band of rows starts from zero.
module yolo_acc_lane #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             add_en,
    input  logic             clr,
    input  logic [9:0]       pix,
    output logic [ACC_W-1:0] acc
);
    always_ff @(posedge clk) begin
        if (rst_n)       acc <= '0;
        else if (add_en) acc <= clr ? '0 : acc + ACC_W'(pix);
    end
endmodule

module yolo_design_wrapper #(
    parameter int IMG_W  = 416,
    parameter int IMG_H  = 416,
    parameter int CELL   = 32,
    parameter int THRESH = 384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] s_axis_0_0_tdata,
    input  logic        s_axis_0_0_tvalid,
    output logic        s_axis_0_0_tready,
    output logic        detect_valid,
    output logic [3:0]  detect_row,
    output logic [3:0]  detect_col,
    output logic [9:0]  detect_score,
    output logic        detect_hit
);
    localparam int NC    = IMG_W / CELL;
    localparam int CB    = $clog2(CELL);
    localparam int SHIFT = 2 * CB;                       // divide by CELL*CELL
    localparam int ACC_W = $clog2(CELL * CELL * 765 + 1);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int CW    = (NC > 1) ? $clog2(NC) : 1;

    logic [XW-1:0]            x;
    logic [YW-1:0]            y;
    logic                     accept;
    logic [9:0]               pix_sum;
    logic [CW-1:0]            col_idx;
    logic                     cell_done;
    logic [NC-1:0][ACC_W-1:0] acc;
    logic [ACC_W-1:0]         cell_sum;
    logic [9:0]               score_next;

    // No internal backpressure: ready follows reset alone.
    assign s_axis_0_0_tready = ~rst_n;
    assign accept    = s_axis_0_0_tvalid & s_axis_0_0_tready;
    assign pix_sum   = 10'(s_axis_0_0_tdata[23:16]) + 10'(s_axis_0_0_tdata[15:8])
                     + 10'(s_axis_0_0_tdata[7:0]);
    assign col_idx   = CW'(x >> CB);
    assign cell_done = accept && (x[CB-1:0] == {CB{1'b1}}) && (y[CB-1:0] == {CB{1'b1}});

    for (genvar i = 0; i < NC; i++) begin : g_lane
        yolo_acc_lane #(.ACC_W(ACC_W)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .add_en (accept && (col_idx == CW'(i))),
            .clr    (cell_done),
            .pix    (pix_sum),
            .acc    (acc[i])
        );
    end

    // The completing pixel has not reached its accumulator yet, so fold it in here.
    assign cell_sum   = acc[col_idx] + ACC_W'(pix_sum);
    assign score_next = 10'(cell_sum >> SHIFT);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            x            <= '0;
            y            <= '0;
            detect_valid <= 1'b0;
            detect_row   <= '0;
            detect_col   <= '0;
            detect_score <= '0;
            detect_hit   <= 1'b0;
        end else begin
            detect_valid <= cell_done;
            if (cell_done) begin
                detect_row   <= 4'(y >> CB);
                detect_col   <= 4'(col_idx);
                detect_score <= score_next;
                detect_hit   <= (score_next >= 10'(THRESH));
            end
            if (accept) begin
                if (x == XW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= (y == YW'(IMG_H - 1)) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_yolo_design_wrapper.sv
// Bench for yolo_design_wrapper on a reduced 96x64 frame (3x2 cells of 32x32)
// so full frames fit in a short run; cell arithmetic is identical to 416x416.
module tb_yolo_design_wrapper;
    localparam int IMG_W = 96, IMG_H = 64, CELL = 32, THRESH = 384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready, detect_valid, detect_hit;
    logic [3:0]  detect_row, detect_col;
    logic [9:0]  detect_score;

    yolo_design_wrapper #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CELL(CELL), .THRESH(THRESH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_0_0_tdata  (tdata),
        .s_axis_0_0_tvalid (tvalid),
        .s_axis_0_0_tready (tready),
        .detect_valid      (detect_valid),
        .detect_row        (detect_row),
        .detect_col        (detect_col),
        .detect_score      (detect_score),
        .detect_hit        (detect_hit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int row; int col; int score; int hit; int cyc; } pulse_t;
    typedef struct { int kind; int gap; int se; int so; int he; int ho; } vec_t;

    pulse_t got_q[$];
    pulse_t exp_q[$];
    int pass_cnt = 0, total_cnt = 0, hold_err = 0;
    int mx = 0, my = 0;

    logic [3:0] lr = '0, lc = '0;
    logic [9:0] ls = '0;
    logic       lh = 1'b0;

    // Capture pulses; between pulses the outputs must hold their last values.
    always @(negedge clk) begin
        if (rst_n) begin
            lr = '0; lc = '0; ls = '0; lh = 1'b0;
        end else if (detect_valid) begin
            got_q.push_back('{int'(detect_row), int'(detect_col), int'(detect_score),
                              int'(detect_hit), cyc});
            lr = detect_row; lc = detect_col; ls = detect_score; lh = detect_hit;
        end else if ({detect_row, detect_col, detect_score, detect_hit} != {lr, lc, ls, lh}) begin
            hold_err++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [23:0] pix(input int kind, input int x, input int y);
        logic [7:0] v;
        case (kind)
            0: return 24'h000000;
            1: return 24'hFFFFFF;
            2: return (((x / CELL) + (y / CELL)) % 2 == 0) ? 24'h404040 : 24'h808080;
            default: begin
                v = 8'((x % CELL) * 8);
                return {v, 16'h0000};
            end
        endcase
    endfunction

    // Drive one pixel (after optional random idle cycles); the model predicts
    // a pulse one cycle after every cell-completing pixel.
    task automatic send(input vec_t v);
        int r, c;
        bit ev;
        while (int'($urandom_range(99)) < v.gap) begin
            @(negedge clk);
            tvalid = 1'b0;
            tdata  = 24'($urandom);
        end
        @(negedge clk);
        tdata  = pix(v.kind, mx, my);
        tvalid = 1'b1;
        if (mx % CELL == CELL - 1 && my % CELL == CELL - 1) begin
            r  = my / CELL;
            c  = mx / CELL;
            ev = ((r + c) % 2 == 0);
            exp_q.push_back('{r, c, ev ? v.se : v.so, ev ? v.he : v.ho, cyc + 1});
        end
        if (mx == IMG_W - 1) begin
            mx = 0;
            my = (my == IMG_H - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tvalid = 1'b0;
            tdata  = 24'($urandom);
        end
    endtask

    task automatic compare_q(input string tag);
        int n;
        check($sformatf("%s pulse_count", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s p%0d row", tag, i),   got_q[i].row,   exp_q[i].row);
            check($sformatf("%s p%0d col", tag, i),   got_q[i].col,   exp_q[i].col);
            check($sformatf("%s p%0d score", tag, i), got_q[i].score, exp_q[i].score);
            check($sformatf("%s p%0d hit", tag, i),   got_q[i].hit,   exp_q[i].hit);
            check($sformatf("%s p%0d cycle", tag, i), got_q[i].cyc,   exp_q[i].cyc);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    vec_t vecs[4];

    initial begin
        // kind, gap%, even score, odd score, even hit, odd hit
        vecs[0] = '{0, 0,   0,   0, 0, 0};   // black
        vecs[1] = '{1, 0, 765, 765, 1, 1};   // white, back to back with black
        vecs[2] = '{2, 30, 192, 384, 0, 1};  // checker with random gaps
        vecs[3] = '{3, 10, 124, 124, 0, 0};  // red ramp 0..248 per cell row

        // Reset with random stimulus
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tdata  = 24'($urandom);
            tvalid = 1'($urandom);
            #1;
            check($sformatf("reset tready c%0d", i), int'(tready), 0);
            check($sformatf("reset valid c%0d", i), int'(detect_valid), 0);
        end
        @(negedge clk);
        tvalid = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("post-reset outputs", int'({detect_row, detect_col, detect_score, detect_hit}), 0);
        check("post-reset tready", int'(tready), 1);

        // Table-driven frames, streamed with no idle between them
        foreach (vecs[k]) begin
            for (int p = 0; p < IMG_W * IMG_H; p++) send(vecs[k]);
        end
        idle(5);
        compare_q("frames");

        // Mid-frame reset: partial checker frame, reset, then a white frame
        for (int p = 0; p < 4000; p++) send(vecs[2]);
        @(negedge clk);
        rst_n  = 1'b1;
        tvalid = 1'b1;
        tdata  = 24'hFFFFFF;
        @(negedge clk);
        #1;
        check("midreset tready", int'(tready), 0);
        check("midreset valid", int'(detect_valid), 0);
        check("midreset outputs", int'({detect_row, detect_col, detect_score, detect_hit}), 0);
        @(negedge clk);
        rst_n = 1'b0;
        tvalid = 1'b0;
        mx = 0;
        my = 0;
        for (int p = 0; p < IMG_W * IMG_H; p++) send(vecs[1]);
        idle(5);
        compare_q("midreset");

        check("hold violations", hold_err, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/yolo_design_wrapper.md
Name: yolo_design_wrapper

Overview:
Top-level streaming detection block for the YOLO system. It accepts a 416x416 RGB frame as an AXI-Stream pixel stream and divides the frame into a 13x13 grid of 32x32-pixel cells. For each cell it accumulates intensity (R+G+B) and emits one scored detection per cell: 169 per frame. Frames arrive back to back; pixel and cell counters wrap automatically.

Parameters:
IMG_W, 416, frame width in pixels (multiple of CELL)
IMG_H, 416, frame height in pixels (multiple of CELL)
CELL, 32, cell edge in pixels (power of two)
THRESH, 384, detect_hit threshold on detect_score

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-high despite the name
s_axis_0_0_tdata  input  24  pixel; [23:16]=R, [15:8]=G, [7:0]=B
s_axis_0_0_tvalid  input  1  pixel valid
s_axis_0_0_tready  output  1  block can accept a pixel
detect_valid  output  1  one-cycle pulse: cell result valid
detect_row  output  4  cell row index 0..12
detect_col  output  4  cell column index 0..12
detect_score  output  10  mean R+G+B over cell, 0..765
detect_hit  output  1  detect_score >= THRESH

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - Clears x, y, all accumulators and all outputs.
  - s_axis_0_0_tready=0, detect_valid=0, detect_row/col/score=0, detect_hit=0.
  - detect_valid must read 0 throughout reset, whatever tdata/tvalid are.
- tready=1 on every cycle reset is not asserted. No internal backpressure.
- Handshake: a pixel is accepted on a rising edge where tvalid=1 and tready=1.
  - Only accepted pixels advance state.
  - When tvalid=0, state holds. Gaps of any length are allowed.
- Raster order: x=0..IMG_W-1 within a row, y=0..IMG_H-1.
  - x wraps to 0 and y increments after each row.
  - After pixel (IMG_W-1, IMG_H-1), x and y wrap to 0. The next accepted pixel starts a new frame with no idle cycle required.
- Accumulators:
  - One per column cell: IMG_W/CELL = 13 entries, 20 bits each (max 1024*765 = 783360).
  - Each accepted pixel adds R+G+B (10-bit, zero-extended) to acc[x/CELL].
- Cell completion: on acceptance of the pixel with x%CELL = CELL-1 and y%CELL = CELL-1 (the last pixel of the cell). On the next rising edge:
  - detect_valid=1
  - detect_row = y/CELL
  - detect_col = x/CELL
  - detect_score = (acc + that pixel's R+G+B) >> log2(CELL*CELL), i.e. >>10
  - detect_hit = score >= THRESH
  - acc[x/CELL] is reset to 0 for the next band.
- Latency: detect_valid asserts exactly 1 cycle after the completing pixel's handshake.
  - detect_valid drops the following cycle unless another cell completes; with CELL=32 the minimum spacing is 32 accepted pixels.
  - detect_row/col/score/hit hold their last values while detect_valid=0.
- Counts: exactly (IMG_W/CELL)*(IMG_H/CELL) = 169 pulses per frame, issued in row-major cell order.
- Reset mid-frame: the partial frame is discarded. No pulse is produced for incomplete cells. The next accepted pixel is treated as (0,0).
- Arithmetic is unsigned; no saturation is needed (widths are sized for the worst case).

Test Plan:
- Reset with random tdata/tvalid for 10 cycles -> tready=0 and detect_valid=0 on every cycle.
- All-black frame: 173056 pixels of 0x000000 with tvalid=1 continuously -> 169 pulses, each score=0, hit=0.
  - First pulse is 1 cycle after pixel index 31*416+31=12927, with row=0, col=0.
- All-white frame: 0xFFFFFF -> 169 pulses, score=765, hit=1. Last pulse has row=12, col=12, 1 cycle after pixel 173055.
- Two frames back to back (black then white) -> exactly 338 detect_valid rising edges. Frame 2's first pulse has row=0, col=0, score=765.
- Cell pattern: cell (r,c) filled with 0x404040 when (r+c) is even and 0x808080 when odd, with random tvalid gaps.
  - Even cells -> score 192, hit=0. Odd cells -> score 384, hit=1.
  - Pulse count and order are unchanged by the gaps.
- Reset after 50000 pixels, then a full white frame -> no stale pulses; 169 pulses, all score=765.
